// File: rtl/veda_mem_pkg.sv
// Shared definitions for the VEDA data memory.
//   DATA_W  : width of one memory word / data bus
//   size_e  : request size encoding (byte, half, word, reserved)
//   state_e : controller states (INIT sweep, IDLE, WAIT, ACCESS, RESP)
package veda_mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    WAIT   = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/veda_mem_lane_align.sv
// Combinational lane handling for sub-word accesses.
// Ports:
//   size        : request size (SIZE_B/H/W/RSV)
//   lane        : byte address bits [1:0]
//   is_unsigned : 1 = zero-extend loads, 0 = sign-extend
//   wdata       : right-aligned store data
//   old_word    : current contents of the addressed word
//   align_err   : size reserved or address misaligned for the size
//   store_word  : old_word with the addressed lanes replaced by wdata
//   load_data   : addressed byte/half/word, extended to 32 bits
module veda_mem_lane_align
  import veda_mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] old_word,
  output logic              align_err,
  output logic [DATA_W-1:0] store_word,
  output logic [DATA_W-1:0] load_data
);

  logic [3:0]        byte_en;
  logic [DATA_W-1:0] wdata_rep;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  always_comb begin
    align_err = (size == SIZE_RSV) ||
                (size == SIZE_H && lane[0]) ||
                (size == SIZE_W && lane != 2'b00);

    // Replicate the store data across the word so each lane can simply
    // pick its own slice when enabled.
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    case (size)
      SIZE_B: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      SIZE_W: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase

    byte_sel = old_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? old_word[31:16] : old_word[15:0];

    case (size)
      SIZE_B:  load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_H:  load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      SIZE_W:  load_data = old_word;
      default: load_data = '0;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_word[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8]
                                               : old_word[gi*8 +: 8];
  end

endmodule

// File: rtl/veda_data_memory.sv
// Word-organised data RAM with byte-addressed, size-qualified load/store.
// Ports:
//   clk, rst          : clock; synchronous active-low reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_we            : 1 = store, 0 = load
//   req_size          : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned      : load zero-extend (1) or sign-extend (0)
//   req_addr          : byte address
//   req_wdata         : right-aligned store data
//   resp_valid        : one-cycle response pulse
//   resp_rdata        : load data / post-store word / 0 on error
//   resp_err          : request rejected
module veda_data_memory
  import veda_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0,
  parameter int INIT_ZERO   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_reg;
  logic [ADDR_W-1:0] init_idx_reg;
  logic [3:0]        wait_cnt_reg;

  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [31:0]       addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rd_word_reg;

  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              range_err;
  logic              align_err;
  logic              req_err;
  logic [DATA_W-1:0] store_word;
  logic [DATA_W-1:0] load_data;

  assign req_ready = (state_reg == IDLE);

  veda_mem_lane_align u_align (
    .size        (size_reg),
    .lane        (addr_reg[1:0]),
    .is_unsigned (uns_reg),
    .wdata       (wdata_reg),
    .old_word    (rd_word_reg),
    .align_err   (align_err),
    .store_word  (store_word),
    .load_data   (load_data)
  );

  assign range_err = (addr_reg[31:ADDR_W+2] != '0);
  assign req_err   = range_err | align_err;

  // While idle the read port follows the incoming address so the old word
  // is already registered when a zero-wait request reaches ACCESS; once a
  // request is latched it keeps re-reading the latched word.
  assign rd_idx = (state_reg == IDLE) ? req_addr[ADDR_W+1:2] : addr_reg[ADDR_W+1:2];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = addr_reg[ADDR_W+1:2];
    wr_data = store_word;
    if (state_reg == INIT) begin
      wr_en   = 1'b1;
      wr_idx  = init_idx_reg;
      wr_data = '0;
    end else if (state_reg == ACCESS && we_reg && !req_err) begin
      wr_en = 1'b1;
    end
  end

  // RAM port: registered read, write suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    rd_word_reg <= mem[rd_idx];
    if (rst && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= (INIT_ZERO != 0) ? INIT : IDLE;
      init_idx_reg <= '0;
      wait_cnt_reg <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_reg)
        INIT: begin
          init_idx_reg <= init_idx_reg + 1'b1;
          if (init_idx_reg == '1) begin
            state_reg <= IDLE;
          end
        end
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            size_reg  <= req_size;
            uns_reg   <= req_unsigned;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            if (WAIT_STATES > 0) begin
              wait_cnt_reg <= 4'(WAIT_STATES - 1);
              state_reg    <= WAIT;
            end else begin
              state_reg <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= ACCESS;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= req_err;
          resp_rdata <= req_err ? '0 : (we_reg ? store_word : load_data);
          state_reg  <= RESP;
        end
        RESP: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_veda_data_memory.sv
// Self-checking bench for veda_data_memory: one instance with no wait
// states and one with three, driven in turn through shared request fields.
// Expected results come from a byte-addressed reference memory.
module tb_veda_data_memory;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  bit          sel;

  logic        valid0, valid3;
  logic        ready0, ready3, rv0, rv3, err0, err3;
  logic [31:0] rd0, rd3;
  logic        ready, rv, errm;
  logic [31:0] rdm;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_m [2][1024];

  always #5 clk = ~clk;

  assign valid0 = req_valid && !sel;
  assign valid3 = req_valid && sel;
  assign ready  = sel ? ready3 : ready0;
  assign rv     = sel ? rv3 : rv0;
  assign errm   = sel ? err3 : err0;
  assign rdm    = sel ? rd3 : rd0;

  veda_data_memory #(.ADDR_W(8), .WAIT_STATES(0), .INIT_ZERO(1)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(valid0), .req_ready(ready0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0)
  );

  veda_data_memory #(.ADDR_W(8), .WAIT_STATES(3), .INIT_ZERO(1)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(valid3), .req_ready(ready3),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory, errors from the size/alignment/range rules.
  task automatic model(input int s, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er);
    int nb;
    int base;
    logic [31:0] v;
    er = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
         (size == 2'd2 && addr[1:0] != 2'b00) || (addr > 32'h3FF);
    rd = '0;
    if (!er) begin
      nb   = 1 << size;
      base = int'(addr);
      if (we) begin
        for (int i = 0; i < nb; i++) mem_m[s][base+i] = wdata[8*i +: 8];
        base = base & ~3;
        for (int i = 0; i < 4; i++) rd[8*i +: 8] = mem_m[s][base+i];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[s][base+i];
        if (!uns && nb < 4 && v[8*nb-1]) begin
          for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        end
        rd = v;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                        input string tag, output logic [31:0] rd, output logic er);
    int n;
    int busy_ready;
    int lat;
    logic [31:0] e_rd;
    logic        e_er;
    lat = sel ? 5 : 2;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!ready && n < 400) begin @(negedge clk); n++; end
    check({tag, " accept_timeout"}, 32'(n >= 400), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    model(int'(sel), we, size, uns, addr, wdata, e_rd, e_er);
    n = 1;
    busy_ready = 0;
    while (!rv && n < 40) begin
      if (ready) busy_ready++;
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    rd = rdm;
    er = errm;
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " ready_while_busy"}, 32'(busy_ready), 32'd0);
    check({tag, " rdata"}, rd, e_rd);
    check({tag, " err"}, 32'(er), 32'(e_er));
    $display("[TB] dut%0d %s we=%0b size=%0d uns=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             sel ? 3 : 0, tag, we, size, uns, addr, wdata, rd, er, n);
    @(negedge clk);
    check({tag, " pulse_width"}, 32'(rv), 32'd0);
  endtask

  // Counts negedges with req_ready low from the current one, plus any responses seen.
  task automatic wait_init(input string tag);
    int n;
    int pulses;
    n = 0;
    pulses = 0;
    while (!ready && n < 1000) begin
      if (rv) pulses++;
      @(negedge clk);
      n++;
    end
    check({tag, " init_cycles"}, 32'(n), 32'd256);
    check({tag, " init_resp"}, 32'(pulses), 32'd0);
    check({tag, " ready_after_init"}, 32'(ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [1:0]  r_size;
  logic [31:0] r_addr;

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) mem_m[s][i] = 8'h00;
    sel = 1'b0;
    rst0 = 1'b0; rst3 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready0", 32'(ready0), 32'd0);
    check("rst resp_valid0", 32'(rv0), 32'd0);
    check("rst rdata0", rd0, 32'd0);
    check("rst err0", 32'(err0), 32'd0);
    check("rst resp_valid3", 32'(rv3), 32'd0);
    check("rst ready3", 32'(ready3), 32'd0);
    @(negedge clk);
    rst0 = 1'b1; rst3 = 1'b1;
    wait_init("dut0");
    check("dut3 ready_after_init", 32'(ready3), 32'd1);

    do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 1'b0, "lw 3fc", rd, er);
    check("lw 3fc const", rd, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h800012F0, 1'b0, "sw 10", rd, er);
    check("sw 10 const", rd, 32'h800012F0);
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0, "lbu 10", rd, er);
    check("lbu 10 const", rd, 32'h000000F0);
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0, "lb 10", rd, er);
    check("lb 10 const", rd, 32'hFFFFFFF0);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, "lh 12", rd, er);
    check("lh 12 const", rd, 32'hFFFF8000);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, "lhu 12", rd, er);
    check("lhu 12 const", rd, 32'h00008000);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, 1'b0, "sb 11", rd, er);
    check("sb 11 const", rd, 32'h8000ABF0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, "lw 10", rd, er);
    check("lw 10 const", rd, 32'h8000ABF0);

    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b0, "lw 12 err", rd, er);
    check("lw 12 err const", {31'd0, er}, 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hDEADBEEF, 1'b0, "sw 12 err", rd, er);
    check("sw 12 err const", {31'd0, er}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, "lw 10 after err", rd, er);
    check("lw 10 after err const", rd, 32'h8000ABF0);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0, "lw 400 err", rd, er);
    check("lw 400 err const", {31'd0, er}, 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0, "size3 err", rd, er);
    check("size3 err const", rd, 32'h0);

    for (int k = 0; k < 150; k++) begin
      r_size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr = 32'($urandom_range(0, 1023));
      if (r_size != 2'd3 && $urandom_range(0, 7) != 0)
        r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      if ($urandom_range(0, 15) == 0) r_addr = $urandom | 32'h400;
      do_req(1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)), r_addr, $urandom,
             1'b0, "rand0", rd, er);
    end

    sel = 1'b1;
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, "sw 40 hold", rd, er);
    for (int k = 0; k < 40; k++) begin
      r_size = 2'($urandom_range(0, 2));
      r_addr = 32'($urandom_range(0, 255)) & ~((32'd1 << r_size) - 32'd1);
      do_req(1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)), r_addr, $urandom,
             1'b0, "rand3", rd, er);
    end

    // Reset in the middle of a wait: the store must vanish without a response.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
    check("rst_mid ready", 32'(ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    check("rst_mid resp_valid", 32'(rv), 32'd0);
    wait_init("dut3 rst_mid");
    for (int i = 0; i < 1024; i++) mem_m[1][i] = 8'h00;
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, "lw 20 after rst", rd, er);
    check("lw 20 after rst const", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
